switch_box_cfg_loader: RTL and testbench

Serial configuration loader for the routing fabric. It receives a framed, bit-serial configuration stream and assembles the `CFG_WIDTH`-bit word that drives a `switch_box`'s `inp_sram` port. The frame is checked for even parity and committed atomically to the output, so the switch box never sees a partially loaded configuration. The block sits directly upstream of `switch_box`, one instance per switch box, with a daisy-chain output for cascading.

---
 rtl/fabric_pkg.sv | 13 +
 rtl/cfg_shift_reg.sv | 32 +++
 rtl/switch_box_cfg_loader.sv | 117 +++++++++++
 tb/tb_switch_box_cfg_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fabric_pkg.sv
// rtl/fabric_pkg.sv - shared routing-fabric types and widths
package fabric_pkg;

    localparam int DEFAULT_CFG_WIDTH = 60;
    localparam int SB_PORT_WIDTH     = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } loader_state_t;

endpackage

// File: rtl/cfg_shift_reg.sv
// rtl/cfg_shift_reg.sv - shadow shift register and running parity for one config frame
module cfg_shift_reg #(
    parameter int CFG_WIDTH = 60
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 acc_en,
    input  logic                 bit_in,
    output logic [CFG_WIDTH-1:0] shadow,
    output logic                 parity
);

    // New bits enter at the MSB and walk down, so beat k ends up in shadow[k].
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            parity <= 1'b0;
        end else begin
            if (clear) begin
                parity <= 1'b0;
            end else if (acc_en) begin
                parity <= parity ^ bit_in;
            end
            if (shift_en) begin
                shadow <= {bit_in, shadow[CFG_WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/switch_box_cfg_loader.sv
// rtl/switch_box_cfg_loader.sv - framed serial loader committing a parity-checked word to inp_sram
module switch_box_cfg_loader
    import fabric_pkg::*;
#(
    parameter int CFG_WIDTH = DEFAULT_CFG_WIDTH,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic                 cfg_in,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [CFG_WIDTH-1:0] inp_sram,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic                 busy,
    output logic                 chain_out
);

    localparam int CNT_W = $clog2(CFG_WIDTH + 1);
    localparam logic [CNT_W-1:0] PARITY_BEAT = CNT_W'(CFG_WIDTH);
    localparam logic [7:0]       IDLE_LIMIT  = 8'(TIMEOUT - 1);

    loader_state_t        state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [7:0]           idle_cnt;
    logic [CFG_WIDTH-1:0] shadow;
    logic                 parity;
    logic                 beat;
    logic                 data_beat;
    logic                 clear;

    // cfg_ready is high exactly in SHIFT; a restart pulse wins over a beat.
    assign beat      = cfg_ready && cfg_valid && !cfg_start;
    assign data_beat = beat && (bit_cnt != PARITY_BEAT);
    assign clear     = cfg_start && (state != ST_COMMIT);

    cfg_shift_reg #(
        .CFG_WIDTH (CFG_WIDTH)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .shift_en (data_beat),
        .acc_en   (beat),
        .bit_in   (cfg_in),
        .shadow   (shadow),
        .parity   (parity)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            inp_sram  <= '0;
            cfg_ready <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            busy      <= 1'b0;
            chain_out <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state     <= ST_SHIFT;
                        bit_cnt   <= '0;
                        idle_cnt  <= '0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cfg_start) begin
                        bit_cnt  <= '0;
                        idle_cnt <= '0;
                        cfg_err  <= 1'b1;
                    end else if (cfg_valid) begin
                        idle_cnt <= '0;
                        if (bit_cnt == PARITY_BEAT) begin
                            // Parity beat: fold it in now so the commit lands next cycle.
                            state     <= ST_COMMIT;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b0;
                            if ((parity ^ cfg_in) == 1'b0) begin
                                inp_sram <= shadow;
                                cfg_done <= 1'b1;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                            chain_out <= shadow[CFG_WIDTH-1];
                        end
                    end else if (idle_cnt == IDLE_LIMIT) begin
                        state     <= ST_IDLE;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b0;
                        cfg_err   <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_box_cfg_loader.sv
// tb/tb_switch_box_cfg_loader.sv - directed scoreboard bench for switch_box_cfg_loader
module tb_switch_box_cfg_loader;

    localparam int W = 60;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_start = 1'b0;
    logic         cfg_in = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] inp_sram;
    logic         cfg_done;
    logic         cfg_err;
    logic         busy;
    logic         chain_out;

    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model_sram = '0;

    typedef struct {
        logic         is_err;
        logic         leaves_shift;
        int           cyc;
        logic [W-1:0] sram;
    } ev_t;

    ev_t sb[$];

    switch_box_cfg_loader #(
        .CFG_WIDTH (W),
        .TIMEOUT   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_in    (cfg_in),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .inp_sram  (inp_sram),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .chain_out (chain_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_evt(input logic is_err, input logic leaves, input int c, input logic [W-1:0] s);
        ev_t e;
        e.is_err       = is_err;
        e.leaves_shift = leaves;
        e.cyc          = c;
        e.sram         = s;
        sb.push_back(e);
    endtask

    // Advance one cycle, sample 1ns after the edge, and score any done/err pulse.
    task automatic tick();
        ev_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (cfg_done || cfg_err) begin
            if (sb.size() == 0) begin
                check("unexpected_evt", {62'd0, cfg_done, cfg_err}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("evt_kind", {62'd0, cfg_done, cfg_err}, e.is_err ? 64'd1 : 64'd2);
                check("evt_cycle", 64'(cyc), 64'(e.cyc));
                check("evt_sram", 64'(inp_sram), 64'(e.sram));
                check("evt_ready", 64'(cfg_ready), e.leaves_shift ? 64'd0 : 64'd1);
                check("evt_busy", 64'(busy), e.leaves_shift ? 64'd0 : 64'd1);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check("missing_evt", {62'd0, cfg_done, cfg_err}, e.is_err ? 64'd1 : 64'd2);
        end
    endtask

    task automatic partial(input int n, input logic [W-1:0] word);
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            cfg_in    = word[i];
            cfg_valid = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic par, input bit stall, input bit restart);
        int t0;
        bit ok;
        t0 = cyc;
        ok = (((^word) ^ par) == 1'b0);
        if (restart) expect_evt(1'b1, 1'b0, t0 + 1, model_sram);
        if (ok) model_sram = word;
        expect_evt(!ok, 1'b1, t0 + 62 + (stall ? 60 : 0), model_sram);
        cfg_start = 1'b1;
        cfg_valid = restart;
        cfg_in    = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i <= W; i++) begin
            cfg_in    = (i < W) ? word[i] : par;
            cfg_valid = 1'b1;
            tick();
            if (stall) begin
                cfg_valid = 1'b0;
                tick();
            end
        end
        cfg_valid = 1'b0;
        tick();
        tick();
        check("frame_drained", 64'(sb.size()), 64'd0);
        check("frame_idle_ready", 64'(cfg_ready), 64'd0);
    endtask

    initial begin
        logic [W-1:0] nominal;
        logic [W-1:0] ones;
        int           t0;
        nominal = 60'h14011111;
        ones    = '1;

        tick();
        tick();
        check("rst_ready", 64'(cfg_ready), 64'd0);
        check("rst_done", 64'(cfg_done), 64'd0);
        check("rst_err", 64'(cfg_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_chain", 64'(chain_out), 64'd0);
        check("rst_sram", 64'(inp_sram), 64'd0);
        reset = 1'b0;
        tick();

        send_frame(nominal, 1'b1, 1'b0, 1'b0);
        check("nominal_chain", 64'(chain_out), 64'(nominal[58]));

        send_frame(nominal, 1'b0, 1'b0, 1'b0);

        send_frame(ones, 1'b0, 1'b1, 1'b0);
        check("stall_chain", 64'(chain_out), 64'd1);

        partial(30, 60'h0A5A5A5A5A5A5A5);
        send_frame(60'h1, 1'b1, 1'b0, 1'b1);

        // Timeout: err shows the cycle after the 8th beatless SHIFT cycle.
        t0 = cyc;
        expect_evt(1'b1, 1'b1, t0 + 19, model_sram);
        partial(10, ones);
        for (int i = 0; i < 7; i++) tick();
        check("timeout_busy_before", 64'(busy), 64'd1);
        tick();
        check("timeout_busy_after", 64'(busy), 64'd0);
        tick();
        check("timeout_drained", 64'(sb.size()), 64'd0);

        partial(40, ones);
        reset = 1'b1;
        tick();
        model_sram = '0;
        check("midrst_ready", 64'(cfg_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(cfg_done), 64'd0);
        check("midrst_err", 64'(cfg_err), 64'd0);
        check("midrst_chain", 64'(chain_out), 64'd0);
        check("midrst_sram", 64'(inp_sram), 64'd0);
        reset = 1'b0;
        tick();
        send_frame(nominal, 1'b1, 1'b0, 1'b0);
        check("final_sram", 64'(inp_sram), 64'(nominal));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
